// File: rtl/tt_sweep_checker.sv
// Truth-table equivalence checker: stores an N_IN-input function, answers
// single-vector lookups and sweeps an external netlist through all vectors.
module tt_sweep_checker #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [(1<<N_IN)-1:0]   cfg_table,
  input  logic                   eval_valid,
  input  logic [N_IN-1:0]        eval_in,
  output logic                   eval_out_valid,
  output logic                   eval_out,
  input  logic                   start,
  output logic                   busy,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_out,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_count,
  output logic                   first_err_valid,
  output logic [N_IN-1:0]        first_err_idx
);

  localparam int TT_W = 1 << N_IN;
  localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TT_W-1:0]   tt;
  logic [N_IN-1:0]   idx;
  logic [CW-1:0]     hold_cnt;
  logic              load_acc;
  logic              start_acc;
  logic              last_idx;
  logic              hold_done;
  logic              mismatch;

  // cfg handshake: a load transfers on any cycle with cfg_valid && cfg_ready;
  // cfg_ready is high only in IDLE and nothing is buffered while it is low.
  assign cfg_ready = (state == IDLE);
  assign load_acc  = cfg_ready && cfg_valid;
  // A load in the same IDLE cycle takes priority and the start is dropped.
  assign start_acc = cfg_ready && !cfg_valid && start;
  assign last_idx  = &idx;
  assign hold_done = (int'(hold_cnt) == SETTLE - 1);
  assign mismatch  = (dut_out != tt[idx]);
  assign dut_in    = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_acc) begin
          state_nxt = (SETTLE == 0) ? SAMPLE : HOLD;
        end
      end
      HOLD: begin
        if (hold_done) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        if (last_idx) begin
          state_nxt = FINISH;
        end else if (SETTLE != 0) begin
          state_nxt = HOLD;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tt              <= '0;
      idx             <= '0;
      hold_cnt        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      eval_out_valid  <= 1'b0;
      eval_out        <= 1'b0;
    end else begin
      done           <= 1'b0;
      // Lookup reads the table before any same-cycle load lands.
      eval_out_valid <= eval_valid;
      if (eval_valid) begin
        eval_out <= tt[eval_in];
      end
      case (state)
        IDLE: begin
          if (load_acc) begin
            tt <= cfg_table;
          end else if (start_acc) begin
            idx             <= '0;
            hold_cnt        <= '0;
            busy            <= 1'b1;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
        end
        SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (!first_err_valid) begin
              first_err_idx   <= idx;
              first_err_valid <= 1'b1;
            end
          end
          if (!last_idx) begin
            idx      <= idx + 1'b1;
            hold_cnt <= '0;
          end
        end
        FINISH: begin
          // err_count already includes the last vector's sample here.
          done <= 1'b1;
          pass <= (err_count == '0);
          busy <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: one instance with SETTLE=1 for the main tests and
// one with SETTLE=0 for the fastest-sweep boundary.
module tb_tt_sweep_checker;

  localparam logic [15:0] TT_REF = 16'hEFEB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance a: SETTLE = 1
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_table = '0;
  logic        eval_valid = 1'b0;
  logic [3:0]  eval_in = '0;
  logic        eval_out_valid;
  logic        eval_out;
  logic        start = 1'b0;
  logic        busy;
  logic [3:0]  dut_in;
  logic        dut_out;
  logic        done;
  logic        pass;
  logic [4:0]  err_count;
  logic        first_err_valid;
  logic [3:0]  first_err_idx;
  logic [15:0] model_tt = TT_REF;

  // instance b: SETTLE = 0
  logic        cfg_valid_b = 1'b0;
  logic        cfg_ready_b;
  logic [15:0] cfg_table_b = '0;
  logic        eval_valid_b = 1'b0;
  logic [3:0]  eval_in_b = '0;
  logic        eval_out_valid_b;
  logic        eval_out_b;
  logic        start_b = 1'b0;
  logic        busy_b;
  logic [3:0]  dut_in_b;
  logic        dut_out_b = 1'b0;
  logic        done_b;
  logic        pass_b;
  logic [4:0]  err_count_b;
  logic        first_err_valid_b;
  logic [3:0]  first_err_idx_b;

  assign dut_out = model_tt[dut_in];

  tt_sweep_checker #(.N_IN(4), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_table(cfg_table),
    .eval_valid(eval_valid), .eval_in(eval_in),
    .eval_out_valid(eval_out_valid), .eval_out(eval_out),
    .start(start), .busy(busy), .dut_in(dut_in), .dut_out(dut_out),
    .done(done), .pass(pass), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_idx(first_err_idx)
  );

  tt_sweep_checker #(.N_IN(4), .SETTLE(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b), .cfg_table(cfg_table_b),
    .eval_valid(eval_valid_b), .eval_in(eval_in_b),
    .eval_out_valid(eval_out_valid_b), .eval_out(eval_out_b),
    .start(start_b), .busy(busy_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
    .done(done_b), .pass(pass_b), .err_count(err_count_b),
    .first_err_valid(first_err_valid_b), .first_err_idx(first_err_idx_b)
  );

  int checks = 0;
  int errors = 0;

  logic [0:0]  exp_q[$];   // eval results, one bit each
  logic [10:0] res_q[$];   // sweep results {pass, first_err_valid, first_err_idx, err_count}
  logic [10:0] res_r;
  int          run_len = 0;
  int          max_run = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // eval scoreboard and burst-length tracking
  always @(negedge clk) begin
    if (eval_out_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        check("eval_out_valid_extra", 32'(eval_out_valid), 32'(0));
      end else begin
        check("eval_out", 32'(eval_out), 32'(exp_q.pop_front()));
      end
    end else begin
      run_len = 0;
    end
  end

  // sweep result scoreboard
  always @(negedge clk) begin
    if (done) begin
      if (res_q.size() == 0) begin
        check("done_unexpected", 32'(done), 32'(0));
      end else begin
        res_r = res_q.pop_front();
        check("err_count", 32'(err_count), 32'(res_r[4:0]));
        check("first_err_valid", 32'(first_err_valid), 32'(res_r[9]));
        check("pass", 32'(pass), 32'(res_r[10]));
        check("busy_at_done", 32'(busy), 32'(0));
        if (res_r[9]) check("first_err_idx", 32'(first_err_idx), 32'(res_r[8:5]));
      end
    end
  end

  task automatic load_a(input logic [15:0] t);
    cfg_valid = 1'b1;
    cfg_table = t;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic eval_burst(input logic [15:0] t);
    max_run = 0;
    for (int i = 0; i < 16; i++) begin
      eval_valid = 1'b1;
      eval_in    = 4'(i);
      exp_q.push_back(t[i]);
      @(posedge clk); #1;
    end
    eval_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("eval_burst_len", 32'(max_run), 32'(16));
  endtask

  task automatic sweep_a(input logic [15:0] model, input logic [10:0] exp_res, input bit poke);
    int n;
    int bad;
    bit got_done;
    model_tt = model;
    res_q.push_back(exp_res);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    bad = 0;
    got_done = 1'b0;
    while (n < 100 && !got_done) begin
      @(negedge clk);
      if (n < 32 && dut_in !== 4'(n / 2)) bad++;
      if (poke && n == 10) begin
        check("busy_mid_sweep", 32'(busy), 32'(1));
        check("cfg_ready_busy", 32'(cfg_ready), 32'(0));
        start     = 1'b1;
        cfg_valid = 1'b1;
        cfg_table = ~model;
      end
      if (poke && n == 11) begin
        start     = 1'b0;
        cfg_valid = 1'b0;
      end
      if (done) got_done = 1'b1;
      else n++;
    end
    check("sweep_done_seen", 32'(got_done), 32'(1));
    check("sweep_latency", 32'(n), 32'(33));
    check("dut_in_hold", 32'(bad), 32'(0));
    @(negedge clk);
    check("done_pulse_width", 32'(done), 32'(0));
    check("dut_in_after_sweep", 32'(dut_in), 32'(15));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    bit got_done;
    logic [15:0] new_tt;

    // reset
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_cfg_ready", 32'(cfg_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_pass", 32'(pass), 32'(0));
    check("rst_err_count", 32'(err_count), 32'(0));
    check("rst_first_err_valid", 32'(first_err_valid), 32'(0));
    check("rst_first_err_idx", 32'(first_err_idx), 32'(0));
    check("rst_dut_in", 32'(dut_in), 32'(0));
    check("rst_eval_out_valid", 32'(eval_out_valid), 32'(0));
    check("rst_eval_out", 32'(eval_out), 32'(0));
    check("rst_b_cfg_ready", 32'(cfg_ready_b), 32'(1));
    check("rst_b_busy", 32'(busy_b), 32'(0));
    check("rst_b_eval_out", 32'({eval_out_valid_b, eval_out_b}), 32'(0));
    check("rst_b_results", 32'({pass_b, first_err_valid_b, first_err_idx_b, err_count_b}), 32'(0));
    @(posedge clk); #1;

    // load and back-to-back lookups
    load_a(TT_REF);
    eval_burst(TT_REF);

    // load and eval in the same cycle: eval sees the old table
    new_tt = 16'h1234;
    cfg_valid  = 1'b1;
    cfg_table  = new_tt;
    eval_valid = 1'b1;
    eval_in    = 4'd0;
    exp_q.push_back(TT_REF[0]);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    exp_q.push_back(new_tt[0]);
    @(posedge clk); #1;
    eval_valid = 1'b0;
    @(posedge clk); #1;
    load_a(TT_REF);

    // clean sweep with start and cfg poked while busy
    sweep_a(TT_REF, {1'b1, 1'b0, 4'd0, 5'd0}, 1'b1);
    eval_burst(TT_REF);

    // fault injection: bits 5 and 12 flipped
    sweep_a(TT_REF ^ 16'h1020, {1'b0, 1'b1, 4'd5, 5'd2}, 1'b0);

    // a cfg load leaves the results alone
    load_a(16'h00FF);
    @(negedge clk);
    check("hold_err_count", 32'(err_count), 32'(2));
    check("hold_first_err_idx", 32'(first_err_idx), 32'(5));
    check("hold_pass", 32'(pass), 32'(0));
    @(posedge clk); #1;
    eval_burst(16'h00FF);

    // cfg_valid and start together in IDLE: load wins
    cfg_valid = 1'b1;
    cfg_table = TT_REF;
    start     = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    check("cfg_start_busy", 32'(busy), 32'(0));
    check("cfg_start_cfg_ready", 32'(cfg_ready), 32'(1));
    repeat (3) @(negedge clk);
    check("cfg_start_busy_later", 32'(busy), 32'(0));
    check("cfg_start_results_kept", 32'(err_count), 32'(2));
    @(posedge clk); #1;
    eval_burst(TT_REF);

    // SETTLE = 0, all-ones table, DUT stuck at 0
    cfg_valid_b = 1'b1;
    cfg_table_b = 16'hFFFF;
    @(posedge clk); #1;
    cfg_valid_b = 1'b0;
    start_b     = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    n = 0;
    bad = 0;
    got_done = 1'b0;
    while (n < 100 && !got_done) begin
      @(negedge clk);
      if (n < 16 && dut_in_b !== 4'(n)) bad++;
      if (n == 5) begin
        eval_valid_b = 1'b1;
        eval_in_b    = 4'd3;
      end
      if (n == 6) begin
        check("b_eval_valid", 32'(eval_out_valid_b), 32'(1));
        check("b_eval_out", 32'(eval_out_b), 32'(1));
        eval_valid_b = 1'b0;
      end
      if (done_b) got_done = 1'b1;
      else n++;
    end
    check("b_done_seen", 32'(got_done), 32'(1));
    check("b_latency", 32'(n), 32'(17));
    check("b_dut_in_seq", 32'(bad), 32'(0));
    check("b_err_count", 32'(err_count_b), 32'(16));
    check("b_first_err_valid", 32'(first_err_valid_b), 32'(1));
    check("b_first_err_idx", 32'(first_err_idx_b), 32'(0));
    check("b_pass", 32'(pass_b), 32'(0));
    check("b_busy_at_done", 32'(busy_b), 32'(0));
    @(posedge clk); #1;

    // reset in the middle of a sweep: no done afterwards
    model_tt = TT_REF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    got_done = 1'b0;
    while (n < 40 && !got_done) begin
      @(negedge clk);
      if (dut_in == 4'd7) got_done = 1'b1;
      else n++;
    end
    check("abort_reached_vec7", 32'(got_done), 32'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_dut_in", 32'(dut_in), 32'(0));
    check("abort_cfg_ready", 32'(cfg_ready), 32'(1));
    check("abort_err_count", 32'(err_count), 32'(0));
    @(posedge clk); #1;
    eval_burst(16'h0000);
    repeat (20) @(posedge clk);
    #1;

    check("eval_queue_drained", 32'(exp_q.size()), 32'(0));
    check("result_queue_drained", 32'(res_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
